// File: rtl/bgsub_pkg.sv
// Shared definitions for the streaming background subtractor:
// FSM state encoding, alpha shift width and width helper functions.
package bgsub_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    localparam int ALPHA_SH_W = 4;

    // Index width for a counter running 0..n-1; never narrower than 1 bit
    function automatic int idx_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // Width that holds the sum of CHANNELS absolute differences without overflow
    function automatic int sum_w(input int pix_w, input int channels);
        return pix_w + $clog2(channels);
    endfunction

endpackage

// File: rtl/bgsub_channel_alu.sv
// One colour channel of the subtractor: signed difference, magnitude and
// floor-shifted update step, registered as pipeline stage 1. The update
// value bg + step is formed combinationally from the stage-1 registers.
module bgsub_channel_alu
    import bgsub_pkg::*;
#(
    parameter int PIX_W = 8
) (
    input  logic                  clk,
    input  logic                  adv,
    input  logic [PIX_W-1:0]      cur,
    input  logic [PIX_W-1:0]      bg,
    input  logic [ALPHA_SH_W-1:0] alpha_sh,
    output logic [PIX_W-1:0]      abs_p1,
    output logic [PIX_W-1:0]      cur_p1,
    output logic [PIX_W-1:0]      bg_p1,
    output logic [PIX_W-1:0]      upd_p1
);

    logic signed [PIX_W:0] diff;
    logic signed [PIX_W:0] step;
    logic signed [PIX_W:0] step_p1;

    // |d| always fits PIX_W bits since d lies in [-(2^PIX_W-1), 2^PIX_W-1]
    function automatic logic [PIX_W-1:0] abs_mag(input logic signed [PIX_W:0] d);
        return PIX_W'((d < 0) ? -d : d);
    endfunction

    // bg + floor(d / 2^sh) stays between bg and cur, so truncation cannot wrap
    function automatic logic [PIX_W-1:0] upd_val(input logic [PIX_W-1:0] b,
                                                 input logic signed [PIX_W:0] s);
        return PIX_W'($signed({1'b0, b}) + s);
    endfunction

    assign diff = $signed({1'b0, cur}) - $signed({1'b0, bg});
    assign step = diff >>> alpha_sh;

    // Stage 1 register: captures diff results whenever the pipe advances
    always_ff @(posedge clk) begin
        if (adv) begin
            abs_p1  <= abs_mag(diff);
            step_p1 <= step;
            cur_p1  <= cur;
            bg_p1   <= bg;
        end
    end

    assign upd_p1 = upd_val(bg_p1, step_p1);

endmodule

// File: rtl/bgsub_stream_core.sv
// Streaming background subtractor top: frame FSM, h/v position counters,
// two-stage pipeline with global stall, threshold compare and background
// update select. Optional foreground pixel counter enabled by defining
// BGSUB_FG_COUNT_EN; otherwise fg_count is tied to zero.
module bgsub_stream_core
    import bgsub_pkg::*;
#(
    parameter int CHANNELS = 3,
    parameter int PIX_W    = 8,
    parameter int H_RES    = 640,
    parameter int V_RES    = 480,
    parameter int THR_W    = 10
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                frame_start,
    input  logic [THR_W-1:0]                    cfg_threshold,
    input  logic [ALPHA_SH_W-1:0]               cfg_alpha_sh,
    input  logic                                cfg_init,
    input  logic                                s_valid,
    output logic                                s_ready,
    input  logic [CHANNELS*PIX_W-1:0]           s_cur,
    input  logic [CHANNELS*PIX_W-1:0]           s_bg,
    output logic                                m_valid,
    input  logic                                m_ready,
    output logic                                m_fg,
    output logic [CHANNELS*PIX_W-1:0]           m_bg_upd,
    output logic                                m_eol,
    output logic                                m_eof,
    output logic                                frame_done,
    output logic                                err_sof,
    output logic [$clog2(H_RES*V_RES+1)-1:0]    fg_count
);

    localparam int PW    = CHANNELS * PIX_W;
    localparam int SUM_W = sum_w(PIX_W, CHANNELS);
    localparam int H_W   = idx_w(H_RES);
    localparam int V_W   = idx_w(V_RES);

    state_t                state;
    logic [THR_W-1:0]      thr_q;
    logic [ALPHA_SH_W-1:0] alpha_q;
    logic                  init_q;
    logic [H_W-1:0]        h_cnt;
    logic [V_W-1:0]        v_cnt;
    logic                  adv, acc, last_h, last_v, out_acc;
    logic                  vld_p1, eol_p1, eof_p1, vld_p2;
    logic [PW-1:0]         abs_p1, cur_p1, bg_p1, upd_p1, bg_upd_p1;
    logic [SUM_W-1:0]      sum_p1;
    logic                  fg_p1;

    assign adv     = ~vld_p2 | m_ready;
    assign s_ready = (state == ST_RUN) && adv;
    assign acc     = s_valid && s_ready;
    assign last_h  = (h_cnt == H_W'(H_RES - 1));
    assign last_v  = (v_cnt == V_W'(V_RES - 1));
    assign out_acc = vld_p2 && m_ready;
    assign m_valid = vld_p2;

    // Frame FSM with config latch, sticky start-of-frame error and done pulse
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            thr_q      <= '0;
            alpha_q    <= '0;
            init_q     <= 1'b0;
            err_sof    <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= out_acc && m_eof;
            if (frame_start && state != ST_IDLE)
                err_sof <= 1'b1;
            case (state)
                ST_IDLE: if (frame_start) begin
                    state   <= ST_RUN;
                    thr_q   <= cfg_threshold;
                    alpha_q <= cfg_alpha_sh;
                    init_q  <= cfg_init;
                end
                ST_RUN:   if (acc && last_h && last_v) state <= ST_FLUSH;
                ST_FLUSH: if (out_acc && m_eof) state <= ST_IDLE;
                default:  state <= ST_IDLE;
            endcase
        end
    end

    // Pixel position counters, advanced once per accepted input beat
    always_ff @(posedge clk) begin
        if (reset) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (acc) begin
            if (last_h) begin
                h_cnt <= '0;
                v_cnt <= last_v ? '0 : v_cnt + V_W'(1);
            end else begin
                h_cnt <= h_cnt + H_W'(1);
            end
        end
    end

    // ---- stage 0 -> stage 1: per-channel diff/abs/step ----
    for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_ch
        bgsub_channel_alu #(.PIX_W(PIX_W)) u_alu (
            .clk      (clk),
            .adv      (adv),
            .cur      (s_cur[ch*PIX_W +: PIX_W]),
            .bg       (s_bg[ch*PIX_W +: PIX_W]),
            .alpha_sh (alpha_q),
            .abs_p1   (abs_p1[ch*PIX_W +: PIX_W]),
            .cur_p1   (cur_p1[ch*PIX_W +: PIX_W]),
            .bg_p1    (bg_p1[ch*PIX_W +: PIX_W]),
            .upd_p1   (upd_p1[ch*PIX_W +: PIX_W])
        );
    end

    // Valid and end-of-line/frame tags travel with the beat; bubbles carry no tags
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_p1 <= 1'b0;
            eol_p1 <= 1'b0;
            eof_p1 <= 1'b0;
            vld_p2 <= 1'b0;
            m_eol  <= 1'b0;
            m_eof  <= 1'b0;
        end else if (adv) begin
            vld_p1 <= acc;
            eol_p1 <= acc && last_h;
            eof_p1 <= acc && last_h && last_v;
            vld_p2 <= vld_p1;
            m_eol  <= eol_p1;
            m_eof  <= eof_p1;
        end
    end

    // ---- stage 1 -> stage 2: sum, threshold, update select ----
    // Channel magnitude sum, foreground decision and selective background update
    always_comb begin
        sum_p1 = '0;
        for (int c = 0; c < CHANNELS; c++)
            sum_p1 = sum_p1 + SUM_W'(abs_p1[c*PIX_W +: PIX_W]);
        fg_p1 = ~init_q && (THR_W'(sum_p1) > thr_q);
        if (init_q)
            bg_upd_p1 = cur_p1;
        else if (fg_p1)
            bg_upd_p1 = bg_p1;
        else
            bg_upd_p1 = upd_p1;
    end

    // Stage 2 output data registers, loaded only by real beats
    always_ff @(posedge clk) begin
        if (reset) begin
            m_fg     <= 1'b0;
            m_bg_upd <= '0;
        end else if (adv && vld_p1) begin
            m_fg     <= fg_p1;
            m_bg_upd <= bg_upd_p1;
        end
    end

`ifdef BGSUB_FG_COUNT_EN
    logic [$clog2(H_RES*V_RES+1)-1:0] fg_acc;

    // Count foreground beats taken downstream; publish and restart at frame end
    always_ff @(posedge clk) begin
        if (reset) begin
            fg_acc   <= '0;
            fg_count <= '0;
        end else if (frame_done) begin
            fg_count <= fg_acc;
            fg_acc   <= '0;
        end else if (out_acc && m_fg) begin
            fg_acc   <= fg_acc + 1'b1;
        end
    end
`else
    assign fg_count = '0;
`endif

endmodule
